// File: rtl/decode38_seq.sv
// Sequenced binary-to-one-hot decoder: buffers {en, code} entries in a small FIFO
// and shows each as a one-hot pattern for HOLD cycles.
module decode38_seq #(
  parameter int W     = 3,
  parameter int DEPTH = 4,
  parameter int HOLD  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_en,
  input  logic [W-1:0]             in_code,
  output logic                     in_ready,
  output logic [(2**W)-1:0]        y,
  output logic                     y_valid,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int N  = 2**W;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic {IDLE, SHOW} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [N-1:0]    y_n;
  logic            y_valid_n;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [W:0]      mem [DEPTH];
  logic [W:0]      rd_entry;
  logic            full, push, pop;

  assign full     = (level == LW'(DEPTH));
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign rd_entry = mem[rd_ptr];
  assign busy     = (state == SHOW) || (level != '0);

  // Storage needs no reset: occupancy is tracked by level/pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_en, in_code};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      y       <= y_n;
      y_valid <= y_valid_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    y_n       = y;
    y_valid_n = y_valid;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (level != '0) pop = 1'b1;
      end
      SHOW: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else if (level != '0) begin
          pop = 1'b1;
        end else begin
          y_n       = '0;
          y_valid_n = 1'b0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // A pop from either state loads the next pattern; blank slots show all-zero.
    if (pop) begin
      y_n                   = '0;
      y_n[rd_entry[W-1:0]]  = rd_entry[W];
      y_valid_n             = 1'b1;
      cnt_n                 = CW'(HOLD - 1);
      state_n               = SHOW;
    end
  end

endmodule
